multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore FSM that sequences the multicycle RISC-V datapath: instruction fetch, decode, execute, memory access and writeback over several cycles.
- Drives every mux select and write enable of the shared datapath (PC, instruction register, one shared memory, register file, ALU).
- Adds memory wait states through mem_ready and a sticky fault state for illegal opcodes or a memory timeout.

Parameters:
MEM_TIMEOUT, 255, wait cycles allowed in a memory-wait state before entering FAULT (1..255).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
op  input  7  opcode field from the instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory access completes this cycle
pc_write  output  1  PC register enable
adr_src  output  1  memory address mux: 0 = PC, 1 = result
mem_write  output  1  memory write enable
ir_write  output  1  instruction/old-PC register enable
result_src  output  2  00 = ALUOut, 01 = memory data, 10 = ALU result
alu_src_a  output  2  00 = PC, 01 = OldPC, 10 = rs1 data
alu_src_b  output  2  00 = rs2 data, 01 = immediate, 10 = constant 4
alu_op  output  2  00 = add, 01 = subtract, 10 = decode by funct
imm_src  output  2  00 = I, 01 = S, 10 = B, 11 = J
reg_write  output  1  register file write enable
instr_done  output  1  one-cycle pulse on the cycle an instruction retires
fault  output  2  00 = none, 01 = illegal opcode, 10 = memory timeout (sticky)

Behaviour:
- State register updates on the rising edge of clk. rst high asynchronously forces state FETCH, wait counter 0, fault 00.
- While rst is high, pc_write, ir_write, mem_write, reg_write and instr_done are forced to 0. All selects take their FETCH values.
- Outputs are combinational from state. The only exceptions are imm_src, pc_write and the mem_ready-gated enables below.
- pc_write = pc_update | (branch & zero). pc_update and branch are internal.
- imm_src is decoded from op in every state: 3/19/103 -> 00, 35 -> 01, 99 -> 10, 111 -> 11, other -> 00.
- Any select not listed for a state is 00. Any enable not listed for a state is 0.
- States and actions:
  - FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
    - ir_write = pc_update = mem_ready.
    - Stay in FETCH until mem_ready, then go to DECODE.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (computes the branch target). Next state by op:
    - 3 or 35 -> MEMADR
    - 51 -> EXECR
    - 19 -> EXECI
    - 111 -> JAL
    - 99 -> BEQ
    - any other value -> FAULT with fault=01
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next is MEMREAD if op==3, else MEMWRITE.
  - MEMREAD: adr_src=1, result_src=00. Wait for mem_ready, then go to MEMWB.
  - MEMWB: result_src=01, reg_write=1, instr_done=1. Next is FETCH.
  - MEMWRITE: adr_src=1, result_src=00, mem_write=1 (held through wait cycles). Leave on mem_ready to FETCH; instr_done=1 on that cycle.
  - EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Next is ALUWB.
  - EXECI: alu_src_a=10, alu_src_b=01, alu_op=10. Next is ALUWB.
  - JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Next is ALUWB.
  - ALUWB: result_src=00, reg_write=1, instr_done=1. Next is FETCH.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1, instr_done=1. Next is FETCH.
  - FAULT: all enables 0. Stays in FAULT until rst.
- Wait counter (8 bits):
  - Cleared on entry to FETCH, MEMREAD or MEMWRITE.
  - Increments each cycle the FSM stays in one of those states with mem_ready=0.
  - When the counter equals MEM_TIMEOUT and mem_ready=0, the next state is FAULT with fault=10.
  - mem_ready=1 on that same cycle wins: the normal transition is taken and no fault is raised.
- The fault register changes only on entry to FAULT or on reset.
- Reset mid-instruction abandons the instruction. No write enable may assert during or after the reset cycle until FETCH runs normally.
- Cycle counts with mem_ready held at 1:
  - lw: 5 cycles
  - sw: 4 cycles
  - R-type / I-type ALU: 4 cycles
  - jal: 4 cycles
  - beq: 3 cycles

Test Plan:
- Reset then release with mem_ready=1 and op=51: states FETCH->DECODE->EXECR->ALUWB. alu_op=10 in EXECR. reg_write=1 and instr_done=1 in cycle 4 only.
- op=3 with mem_ready=1 -> 5-cycle sequence ending in MEMWB with result_src=01 and reg_write=1. Repeat with mem_ready low for 3 cycles in MEMREAD -> exactly 3 extra cycles, no write enables during the wait.
- op=99: zero=1 -> pc_write=1 in BEQ with alu_op=01. zero=0 -> pc_write=0. Both cases return to FETCH after 3 cycles.
- op=35 -> mem_write=1 and adr_src=1 in MEMWRITE, imm_src=01 throughout. op=111 -> pc_write=1 in JAL, then reg_write in ALUWB.
- op=0 after FETCH -> FAULT with fault=01. FSM holds for 20 cycles with all enables 0. rst pulse -> FETCH, fault=00.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> FAULT with fault=10 after 5 cycles. Same setup with mem_ready=1 on the timeout cycle -> DECODE, no fault. Asynchronous rst asserted mid-EXECI -> immediate FETCH, reg_write never asserted.

Source files
------------

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RISC-V datapath: fetch/decode/execute/memory/writeback
// sequencing, memory wait states via mem_ready, and a sticky fault state.
module multicycle_controller #(
   parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] imm_src,
   output logic       reg_write,
   output logic       instr_done,
   output logic [1:0] fault
);

   localparam logic [3:0] S_FETCH    = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_MEMADR   = 4'd2;
   localparam logic [3:0] S_MEMREAD  = 4'd3;
   localparam logic [3:0] S_MEMWB    = 4'd4;
   localparam logic [3:0] S_MEMWRITE = 4'd5;
   localparam logic [3:0] S_EXECR    = 4'd6;
   localparam logic [3:0] S_EXECI    = 4'd7;
   localparam logic [3:0] S_JAL      = 4'd8;
   localparam logic [3:0] S_ALUWB    = 4'd9;
   localparam logic [3:0] S_BEQ      = 4'd10;
   localparam logic [3:0] S_FAULT    = 4'd11;

   logic [3:0] state_q, state_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic [1:0] fault_q, fault_d;
   logic       timeout_s;
   logic       in_wait_s;
   logic       pc_update_s, branch_s, ir_write_s, mem_write_s, reg_write_s, done_s;

   assign timeout_s = (wait_cnt_q == MEM_TIMEOUT) && !mem_ready;
   assign in_wait_s = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);

   // State, wait counter and sticky fault registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= 8'd0;
         fault_q    <= 2'b00;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         fault_q    <= fault_d;
      end
   end

   // Next-state selection; mem_ready beats a coincident timeout
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    state_d = mem_ready ? S_DECODE : (timeout_s ? S_FAULT : S_FETCH);
         S_DECODE: begin
            case (op)
               7'd3, 7'd35: state_d = S_MEMADR;
               7'd51:       state_d = S_EXECR;
               7'd19:       state_d = S_EXECI;
               7'd111:      state_d = S_JAL;
               7'd99:       state_d = S_BEQ;
               default:     state_d = S_FAULT;
            endcase
         end
         S_MEMADR:   state_d = (op == 7'd3) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = mem_ready ? S_MEMWB : (timeout_s ? S_FAULT : S_MEMREAD);
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: state_d = mem_ready ? S_FETCH : (timeout_s ? S_FAULT : S_MEMWRITE);
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_JAL:      state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BEQ:      state_d = S_FETCH;
         S_FAULT:    state_d = S_FAULT;
         default:    state_d = S_FETCH;
      endcase
   end

   // Wait counter restarts on every state change; fault code latched only on FAULT entry
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      fault_d    = fault_q;
      if (state_d != state_q) begin
         wait_cnt_d = 8'd0;
      end else if (in_wait_s && !mem_ready) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end else begin
         wait_cnt_d = wait_cnt_q;
      end
      if ((state_d == S_FAULT) && (state_q != S_FAULT)) begin
         fault_d = (state_q == S_DECODE) ? 2'b01 : 2'b10;
      end else begin
         fault_d = fault_q;
      end
   end

   // Per-state datapath controls
   always_comb begin
      adr_src     = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_op      = 2'b00;
      pc_update_s = 1'b0;
      branch_s    = 1'b0;
      ir_write_s  = 1'b0;
      mem_write_s = 1'b0;
      reg_write_s = 1'b0;
      done_s      = 1'b0;
      case (state_q)
         S_FETCH: begin
            alu_src_b   = 2'b10;
            result_src  = 2'b10;
            ir_write_s  = mem_ready;
            pc_update_s = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
         end
         S_MEMREAD:  adr_src = 1'b1;
         S_MEMWB: begin
            result_src  = 2'b01;
            reg_write_s = 1'b1;
            done_s      = 1'b1;
         end
         S_MEMWRITE: begin
            adr_src     = 1'b1;
            mem_write_s = 1'b1;
            done_s      = mem_ready;
         end
         S_EXECR: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
         end
         S_EXECI: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
         end
         S_JAL: begin
            alu_src_a   = 2'b01;
            alu_src_b   = 2'b10;
            pc_update_s = 1'b1;
         end
         S_ALUWB: begin
            reg_write_s = 1'b1;
            done_s      = 1'b1;
         end
         S_BEQ: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            branch_s  = 1'b1;
            done_s    = 1'b1;
         end
         default: begin
            adr_src = 1'b0;
         end
      endcase
   end

   // Immediate format follows the opcode regardless of state
   always_comb begin
      case (op)
         7'd35:   imm_src = 2'b01;
         7'd99:   imm_src = 2'b10;
         7'd111:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   assign pc_write   = (pc_update_s | (branch_s & zero)) & ~rst;
   assign ir_write   = ir_write_s & ~rst;
   assign mem_write  = mem_write_s & ~rst;
   assign reg_write  = reg_write_s & ~rst;
   assign instr_done = done_s & ~rst;
   assign fault      = fault_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench: each instruction is expanded into its expected
// per-cycle control vectors from the opcode, stall lengths and zero flag.
module tb_multicycle_controller;

   localparam int T = 4;

   logic       clk = 1'b0;
   logic       rst_s = 1'b1;
   logic [6:0] op_s = 7'd0;
   logic       zero_s = 1'b0;
   logic       ready_s = 1'b0;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src, fault;
   logic [17:0] obs_s;
   logic [1:0]  flt_m = 2'b00;
   int total_cnt = 0;
   int bad_cnt = 0;

   multicycle_controller #(.MEM_TIMEOUT(8'd4)) dut (
      .clk(clk), .rst(rst_s), .op(op_s), .zero(zero_s), .mem_ready(ready_s),
      .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .imm_src(imm_src), .reg_write(reg_write),
      .instr_done(instr_done), .fault(fault)
   );

   always #5 clk = ~clk;

   assign obs_s = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                   alu_src_b, alu_op, imm_src, reg_write, instr_done, fault};

   task automatic check_val(input string tag, input logic [17:0] obs, input logic [17:0] exp);
      total_cnt++;
      if (obs !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %b expected %b (op=%0d t=%0t)", tag, obs, exp, op_s, $time);
      end
   endtask

   function automatic logic [1:0] imm_of(input logic [6:0] o);
      if (o == 7'd35) return 2'b01;
      if (o == 7'd99) return 2'b10;
      if (o == 7'd111) return 2'b11;
      return 2'b00;
   endfunction

   // Expected vector: pcw, adr, mw, irw, result, srcA, srcB, aluop, rw, done
   function automatic logic [17:0] ev(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] rs, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] aop,
                                      input logic rw, input logic done);
      return {pcw, adr, mw, irw, rs, a, b, aop, imm_of(op_s), rw, done, flt_m};
   endfunction

   task automatic step(input logic rdy, input logic z, input logic [17:0] exp, input string tag);
      ready_s = rdy;
      zero_s  = z;
      @(negedge clk);
      check_val(tag, obs_s, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_s   = 1'b1;
      flt_m   = 2'b00;
      ready_s = 1'b1;
      @(negedge clk);
      check_val("reset", obs_s, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      rst_s = 1'b0;
   endtask

   // Memory-wait phase: the timeout fires on the (T+1)th consecutive not-ready cycle
   task automatic wait_phase(input int stalls, input logic z, input logic [17:0] se,
                             input logic [17:0] re, input string tag, output bit hit);
      int n0;
      n0  = (stalls > T + 1) ? T + 1 : stalls;
      hit = 1'b0;
      for (int i = 0; i < n0; i++) step(1'b0, z, se, {tag, "_wait"});
      if (stalls > T) hit = 1'b1;
      else step(1'b1, z, re, tag);
   endtask

   task automatic fault_hold(input logic [1:0] code, input int n);
      flt_m = code;
      for (int i = 0; i < n; i++)
         step(1'($urandom), 1'($urandom), ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0), "fault_hold");
      apply_reset();
   endtask

   task automatic do_instr(input logic [6:0] o, input int fst, input int mst, input logic z, input int hold);
      bit hit;
      logic [17:0] se, re, aluwb;
      op_s  = o;
      aluwb = ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1);
      wait_phase(fst, z, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0),
                 ev(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0), "fetch", hit);
      if (hit) begin fault_hold(2'b10, hold); return; end
      step(1'($urandom), z, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0), "decode");
      case (o)
         7'd3, 7'd35: begin
            step(1'($urandom), z, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0), "memadr");
            if (o == 7'd3) begin
               se = ev(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
               wait_phase(mst, z, se, se, "memread", hit);
               if (hit) begin fault_hold(2'b10, hold); return; end
               step(1'($urandom), z, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1), "memwb");
            end else begin
               se = ev(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
               re = ev(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
               wait_phase(mst, z, se, re, "memwrite", hit);
               if (hit) begin fault_hold(2'b10, hold); return; end
            end
         end
         7'd51: begin
            step(1'($urandom), z, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0), "execr");
            step(1'($urandom), z, aluwb, "aluwb");
         end
         7'd19: begin
            step(1'($urandom), z, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0), "execi");
            step(1'($urandom), z, aluwb, "aluwb");
         end
         7'd111: begin
            step(1'($urandom), z, ev(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0), "jal");
            step(1'($urandom), z, aluwb, "aluwb");
         end
         7'd99: step(1'($urandom), z, ev(z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b1), "beq");
         default: fault_hold(2'b01, hold);
      endcase
   endtask

   // Asynchronous reset in the middle of an I-type execute must abandon it with no write
   task automatic reset_mid_execi();
      op_s = 7'd19;
      step(1'b1, 1'b0, ev(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0), "rx_fetch");
      step(1'b1, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0), "rx_decode");
      @(negedge clk);
      check_val("rx_execi", obs_s, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0));
      #2 rst_s = 1'b1;
      #1 check_val("rx_async", obs_s, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      rst_s = 1'b0;
   endtask

   initial begin : main
      logic [6:0] legal [6];
      logic [6:0] o;
      int r, fst, mst;
      legal[0] = 7'd3;  legal[1] = 7'd35; legal[2] = 7'd51;
      legal[3] = 7'd19; legal[4] = 7'd111; legal[5] = 7'd99;
      @(posedge clk);
      #1;
      apply_reset();
      do_instr(7'd51, 0, 0, 1'b0, 3);
      do_instr(7'd3, 0, 0, 1'b0, 3);
      do_instr(7'd3, 0, 3, 1'b1, 3);
      do_instr(7'd99, 0, 0, 1'b1, 3);
      do_instr(7'd99, 0, 0, 1'b0, 3);
      do_instr(7'd35, 0, 2, 1'b0, 3);
      do_instr(7'd111, 0, 0, 1'b1, 3);
      do_instr(7'd0, 0, 0, 1'b0, 20);
      do_instr(7'd51, T, 0, 1'b0, 3);
      do_instr(7'd51, T + 1, 0, 1'b0, 3);
      do_instr(7'd3, 1, T + 1, 1'b0, 3);
      do_instr(7'd35, 0, T, 1'b0, 3);
      do_instr(7'd35, 0, T + 1, 1'b0, 3);
      reset_mid_execi();
      do_instr(7'd19, 0, 0, 1'b0, 3);
      for (int k = 0; k < 300; k++) begin
         r = $urandom_range(0, 9);
         o = (r < 9) ? legal[$urandom_range(0, 5)] : 7'($urandom);
         r = $urandom_range(0, 9);
         fst = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, T) : $urandom_range(T + 1, T + 2);
         r = $urandom_range(0, 9);
         mst = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, T) : $urandom_range(T + 1, T + 2);
         if ($urandom_range(0, 19) == 0) reset_mid_execi();
         do_instr(o, fst, mst, 1'($urandom), 3);
      end
      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
